// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction side in, decoded immediate side out.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      illegal_cnt;

    modport master (output flush, in_valid, in_inst, in_tag, out_ready,
                    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag, illegal_cnt);
    modport slave  (input  flush, in_valid, in_inst, in_tag, out_ready,
                    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag, illegal_cnt);
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate decoder feeding a small valid/ready output FIFO.
// Decode is combinational on the offered word; only the FIFO is registered.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_pipe_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_X} fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0]     inst;
    logic [4:0]      opc;
    logic [2:0]      f3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    entry_t          dec;

    assign inst     = bus.in_inst;
    assign opc      = inst[6:2];
    assign f3       = inst[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    assign imm_i    = XLEN'($signed(inst[31:20]));
    assign imm_s    = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b    = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u    = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j    = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    always_comb begin
        dec.imm     = '0;
        dec.fmt     = FMT_X;
        dec.tag     = bus.in_tag;
        if (inst[1:0] == 2'b11) begin
            case (opc)
                5'b00000, 5'b00011, 5'b11001: begin
                    dec.fmt = FMT_I;
                    dec.imm = imm_i;
                end
                5'b00100: begin
                    if (!is_shift) begin
                        dec.fmt = FMT_I;
                        dec.imm = imm_i;
                    end else if (XLEN == 64 || !inst[25]) begin
                        // inst[25] is zero whenever this is reached on RV32
                        dec.fmt = FMT_I;
                        dec.imm = XLEN'(inst[25:20]);
                    end
                end
                5'b00110: begin
                    if (XLEN == 64) begin
                        dec.fmt = FMT_I;
                        dec.imm = is_shift ? XLEN'(inst[24:20]) : imm_i;
                    end
                end
                5'b01000: begin
                    dec.fmt = FMT_S;
                    dec.imm = imm_s;
                end
                5'b11000: begin
                    dec.fmt = FMT_B;
                    dec.imm = imm_b;
                end
                5'b01101, 5'b00101: begin
                    dec.fmt = FMT_U;
                    dec.imm = imm_u;
                end
                5'b11011: begin
                    dec.fmt = FMT_J;
                    dec.imm = imm_j;
                end
                5'b11100: begin
                    if (f3 inside {3'b101, 3'b110, 3'b111}) begin
                        dec.fmt = FMT_Z;
                        dec.imm = XLEN'(inst[19:15]);
                    end else begin
                        dec.fmt = FMT_I;
                        dec.imm = imm_i;
                    end
                end
                5'b01100: dec.fmt = FMT_R;
                5'b01110: if (XLEN == 64) dec.fmt = FMT_R;
                default: ;
            endcase
        end
        dec.illegal = (dec.fmt == FMT_X);
    end

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   ill_cnt_q, ill_cnt_d;
    logic          push, pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Readiness depends on registered occupancy only, so no path from out_ready
    assign bus.in_ready  = (cnt_q != CW'(DEPTH));
    assign bus.out_valid = (cnt_q != '0);
    assign push          = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop           = bus.out_valid && bus.out_ready && !bus.flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        ill_cnt_d = ill_cnt_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wrap_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
        if (push && dec.illegal && ill_cnt_q != 16'hFFFF) ill_cnt_d = ill_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ill_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    assign head            = bus.out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.out_imm     = head.imm;
    assign bus.out_fmt     = head.fmt;
    assign bus.out_illegal = head.illegal;
    assign bus.out_tag     = head.tag;
    assign bus.illegal_cnt = ill_cnt_q;
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the pipelined RV32I/RV64I core. It sits between fetch and register-read and decodes every immediate format, including shift amounts and CSR zimm. It also flags malformed or unsupported opcodes and buffers results in a small output FIFO with valid/ready handshakes on both sides. XLEN is selectable, and a sideband tag travels with each instruction.

## Interface
- XLEN, 32: datapath width; 32 or 64 only.
- DEPTH, 2: output FIFO entries; 2..8.
- TAG_W, 8: sideband tag width (PC index, ROB id, etc.).
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; empties FIFO.
- in_valid  in  1  instruction offered.
- in_ready  out  1  FIFO can accept.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_imm  out  XLEN  immediate, sign- or zero-extended to XLEN.
- out_fmt  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 X (illegal).
- out_illegal  out  1  instruction not decodable.
- out_tag  out  TAG_W  tag of head entry.
- illegal_cnt  out  16  saturating count of illegal instructions accepted.

## Operation
- Decode is combinational on in_inst. The result {imm, fmt, illegal, tag} is written to the FIFO tail on push.
- Opcode selection uses inst[6:2]. inst[1:0] != 2'b11 gives X.
- LOAD 00000, MISC-MEM 00011, JALR 11001: I, imm = sext(inst[31:20]).
- OP-IMM 00100: I.
  - Shifts (funct3 001/101): imm = zext(inst[25:20]) for XLEN=64, zext(inst[24:20]) for XLEN=32.
  - XLEN=32 with inst[25]=1 on a shift gives X.
  - Other funct3 values: sext(inst[31:20]).
- OP-IMM-32 00110: XLEN=64 only, I; shifts use zext(inst[24:20]). Gives X when XLEN=32.
- STORE 01000: S, sext({inst[31:25], inst[11:7]}).
- BRANCH 11000: B, sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- LUI 01101, AUIPC 00101: U, sext({inst[31:12], 12'b0}) to XLEN.
- JAL 11011: J, sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- SYSTEM 11100:
  - funct3 101/110/111: Z, imm = zext(inst[19:15]).
  - Other funct3 values: I.
- OP 01100 and OP-32 01110 (OP-32 XLEN=64 only): R, imm = 0.
- Any other opcode: X, imm = 0, illegal = 1.
- Push occurs when in_valid && in_ready && !flush.
- Pop occurs when out_valid && out_ready && !flush.
- Push and pop in the same cycle are both performed; count is unchanged.
- in_ready = (count < DEPTH). It is a function of registered count only, never of out_ready.
- out_valid = (count != 0).
- out_imm, out_fmt, out_illegal and out_tag show the head entry. All four are forced to 0 while out_valid = 0.
- illegal_cnt increments on each push with illegal = 1 and saturates at 16'hFFFF. It is not cleared by flush.
- flush sets count to 0 and resets the pointers. Any push or pop in the same cycle is discarded.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_imm = 0, out_fmt = 0, out_illegal = 0, out_tag = 0, illegal_cnt = 0. Pointers and count are 0.
- Latency: an instruction pushed at edge N is presented with out_valid = 1 after edge N (same-cycle bypass is not allowed). Minimum one cycle from in to out.
- Throughput: one instruction per cycle while the consumer keeps out_ready = 1.
- Full (count = DEPTH): in_ready = 0. It rises the cycle after a pop.
- Empty (count = 0): out_valid = 0. out_ready is ignored.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Order is strict FIFO; tags emerge in push order.
- Reset asserted mid-stream discards all entries immediately (asynchronous). Outputs take their reset values without waiting for a clock.
- Holding rules: out_* are stable while out_valid && !out_ready. Producer inputs are sampled only on push.

## Test plan
- XLEN=32: push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, fmt=1; push 0xFE112E23 (sw) -> imm=0xFFFFFFFC, fmt=2.
- XLEN=32: push 0x0080006F (jal +8) -> imm=0x00000008, fmt=5; push 0x3007D073 (csrrwi) -> imm=0x0000000F, fmt=6.
- XLEN=64: push 0x80000037 (lui) -> imm=0xFFFFFFFF80000000, fmt=4; push 0x02109093 (slli x1,x1,33) -> imm=33, fmt=1. Same slli with XLEN=32 -> illegal=1, fmt=7.
- Push 0x00000000 twice -> fmt=7, imm=0, illegal=1; illegal_cnt=2. Preload 16'hFFFE, push three illegals -> illegal_cnt holds 16'hFFFF.
- DEPTH=2, out_ready=0, offer tags 1,2,3 back-to-back -> in_ready drops after 2 pushes. Raise out_ready -> tags 1,2 then 3 emerge in order, no loss.
- With 2 entries queued, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, flushed push absent. Assert rst_n=0 mid-stream -> all outputs 0 immediately.
